// File: rtl/cos_sim_pkg.sv
// Shared definitions for the cosine-similarity micro-sequencer: state
// encoding, micro-program landmarks and the op-code type.
package cos_sim_pkg;

  localparam int unsigned OP_W  = 4;
  localparam int unsigned LEN_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } seq_state_e;

  // Micro-program landmarks: 3 init steps, a 7-step loop body, 3 finalize steps
  localparam int unsigned STEP_INIT0 = 0;
  localparam int unsigned LOOP_START = 3;
  localparam int unsigned LOOP_END   = 9;
  localparam int unsigned FIN_START  = 10;
  localparam int unsigned LAST_STEP  = 12;
  localparam int unsigned NUM_STEPS  = 13;

  typedef logic [OP_W-1:0] op_code_t;

endpackage

// File: rtl/cos_sim_iter_cnt.sv
// Loop iteration counter: cleared at the start of a run, bumped each time the
// loop body wraps, and flags the final iteration against the latched length.
module cos_sim_iter_cnt #(
  parameter int unsigned LW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          inc_i,
  input  logic [LW-1:0] len_i,
  output logic [LW-1:0] cnt_o,
  output logic          last_o
);

  logic [LW-1:0] cnt_q;
  logic [LW-1:0] cnt_d;

  // Clear wins over increment so a restart never carries a stale count
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + LW'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A zero length never reaches the loop, so len-1 is only meaningful when len is non-zero
  assign last_o = (len_i != '0) && (cnt_q == (len_i - LW'(1)));
  assign cnt_o  = cnt_q;

endmodule

// File: rtl/cos_sim_seq.sv
// Micro-sequencer: owns the program counter, walks init / loop / finalize
// steps and hands each one to the datapath over a valid/ready handshake.
module cos_sim_seq
  import cos_sim_pkg::*;
#(
  parameter int unsigned W  = OP_W,
  parameter int unsigned LW = LEN_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic [LW-1:0] vec_len,
  output logic          op_valid,
  output logic [W-1:0]  op_code,
  input  logic          op_ready,
  output logic [LW-1:0] iter,
  output logic          busy,
  output logic          done
);

  seq_state_e    state_q, state_d;
  logic [W-1:0]  pc_q, pc_d;
  logic [LW-1:0] len_q, len_d;
  logic          iterClr;
  logic          iterInc;
  logic          iterLast;
  logic          xfer;

  assign xfer = (state_q == RUN) && op_ready;

  // Next-state and next-pc: abort beats start, start beats a step transfer
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    len_d   = len_q;
    iterClr = 1'b0;
    iterInc = 1'b0;
    if (abort) begin
      state_d = IDLE;
      pc_d    = W'(STEP_INIT0);
      iterClr = 1'b1;
    end else if (start && (state_q != RUN)) begin
      state_d = RUN;
      pc_d    = W'(STEP_INIT0);
      iterClr = 1'b1;
      len_d   = vec_len;
    end else if (xfer) begin
      if (pc_q == W'(LAST_STEP)) begin
        state_d = DONE;
        pc_d    = W'(STEP_INIT0);
      end else if ((pc_q == W'(LOOP_START - 1)) && (len_q == '0)) begin
        pc_d = W'(FIN_START);
      end else if (pc_q == W'(LOOP_END)) begin
        if (iterLast) begin
          pc_d = W'(FIN_START);
        end else begin
          pc_d    = W'(LOOP_START);
          iterInc = 1'b1;
        end
      end else begin
        pc_d = pc_q + W'(1);
      end
    end
  end

  // State, program counter and latched vector length
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= W'(STEP_INIT0);
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      len_q   <= len_d;
    end
  end

  cos_sim_iter_cnt #(
    .LW(LW)
  ) u_iter_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (iterClr),
    .inc_i (iterInc),
    .len_i (len_q),
    .cnt_o (iter),
    .last_o(iterLast)
  );

  // Outputs decode straight from registered state, so op_ready never reaches op_valid
  assign op_valid = (state_q == RUN);
  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);
  assign op_code  = pc_q;

endmodule

// File: doc/cos_sim_seq.md
# cos_sim_seq

Micro-sequencer for the cosine-similarity accelerator. It owns the 4-bit program counter (CSAR) and walks the 13-step micro-program:
- 3 init steps,
- a 7-step loop body repeated once per vector element,
- 3 finalize steps.

Each step is issued to the datapath over a valid/ready handshake. It sits between the CroC memory-mapped control registers (start, abort, vector length, status) and the cosine-similarity datapath.

## Interface
- W, 4: PC / op-code width; 13 steps fit in 4 bits.
- LW, 8: vector-length and iteration-counter width.

- clk  in  1  system clock.
- rst_n  in  1  one clock; reset is asynchronous and active-low.
- start  in  1  single-cycle pulse from the memory-mapped control register.
- abort  in  1  single-cycle pulse; cancels the run.
- vec_len  in  LW  element count N; sampled on accepted start.
- op_valid  out  1  a step is being presented to the datapath.
- op_code  out  W  current step index, equal to the PC.
- op_ready  in  1  datapath accepts the step.
- iter  out  LW  current loop iteration, 0-based.
- busy  out  1  run in progress.
- done  out  1  sticky completion flag.

## Operation
- States:
  - IDLE: op_valid=0, busy=0.
  - RUN: busy=1, op_valid=1.
  - DONE: done=1, busy=0, op_valid=0.
- IDLE or DONE, start=1: go to RUN; pc=0, iter=0, done=0, latch vec_len into len_q.
- RUN:
  - op_code=pc is held stable while op_valid && !op_ready.
  - A transfer is op_valid && op_ready.
  - Only a transfer advances pc.
- Next-pc on transfer:
  - pc 0,1: pc+1.
  - pc 2: if len_q==0 then 10, else 3.
  - pc 3..8: pc+1.
  - pc 9, iter==len_q-1: pc=10; iter holds.
  - pc 9, otherwise: pc=3, iter+1.
  - pc 10,11: pc+1.
  - pc 12: go to DONE; pc returns to 0.
- Total transfers per run: 6 + 7·N.
- start while in RUN is ignored. vec_len changes during RUN are ignored.
- abort in any state: next cycle IDLE, pc=0, iter=0, done=0.
- Priority: abort > start > transfer. A transfer coinciding with abort still completes on the datapath side, but the PC does not advance.
- DONE holds until start (new run) or abort (back to IDLE).
- iter arithmetic is unsigned LW-bit. len_q−1 is evaluated only when len_q≠0, so there is no wrap.

## Timing
- Reset values: state IDLE, pc 0, iter 0, len_q 0, op_valid 0, op_code 0, busy 0, done 0.
- All outputs are registered or decoded directly from registered state; there is no combinational path from op_ready to op_valid.
- start at cycle c: busy=1, op_valid=1, op_code=0 at c+1.
- One transfer per cycle maximum. With op_ready held at 1, step k is presented the cycle after step k−1 is accepted.
- Transfer of step 12 at cycle t: done=1, busy=0 at t+1.
- With op_ready=1 and N=1, start at cycle 0:
  - ops appear at cycles 1..13;
  - done=1 at cycle 14.
- Back-to-back: start in the same cycle that done is first visible begins a new run the following cycle.

## Structure
- Shared package cos_sim_pkg holds:
  - enum seq_state_e {IDLE, RUN, DONE};
  - localparams STEP_INIT0=0, LOOP_START=3, LOOP_END=9, FIN_START=10, LAST_STEP=12, NUM_STEPS=13;
  - a typedef for the W-bit op code.
- One natural sub-module: cos_sim_iter_cnt.
  - LW-bit counter with clear, increment and terminal-count compare against len_q.
  - Same async active-low reset.
- PC register, FSM and next-pc mux live in the top.

## Test plan
- Reset mid-run (rst_n low at pc=5, iter=1) -> all outputs at reset values immediately; IDLE after release, no ops issued.
- N=2, op_ready=1, start at cycle 0:
  - 20 transfers, sequence 0,1,2,3..9,3..9,10,11,12;
  - iter 0 then 1;
  - done=1 at cycle 21.
- N=0, op_ready=1 -> sequence 0,1,2,10,11,12; done at cycle 7; iter stays 0.
- N=1, op_ready pseudo-random 50% -> op_code stable while stalled; 13 transfers in order; start pulses during RUN ignored.
- N=3, abort at the transfer of step 6 in iteration 1 -> IDLE next cycle; pc=0, iter=0, done=0; no further op_valid.
- N=255 (max) -> 1791 transfers; iter reaches 254, no wrap; done asserted. Then start again without abort -> clean second run from pc=0.
